// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment display: segment
// patterns (active-low {g,f,e,d,c,b,a}), digit count, anode-off value and
// the encoding of the field being edited.
package seg_pkg;

   localparam int NUM_DIGITS = 6;

   localparam logic [7:0] ANODE_OFF = 8'hFF;

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;

   typedef enum logic [1:0] {
      SEL_SEC  = 2'd0,
      SEL_MIN  = 2'd1,
      SEL_HOUR = 2'd2,
      SEL_NONE = 2'd3
   } sel_field_t;

   // Active-low one-hot anode pattern for a digit position; bits 7:6 stay off.
   function automatic logic [7:0] anode_for(input logic [2:0] pos);
      return ~(8'h01 << pos);
   endfunction

endpackage

// File: rtl/seg_bcd_decoder.sv
// Combinational BCD to seven-segment decoder, active-low {g,f,e,d,c,b,a}.
// Codes 10..15 are not valid time digits and show a dash.
module seg_bcd_decoder
   import seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Look up the segment pattern; anything outside 0..9 becomes a dash.
   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg_scan_display.sv
// Six-digit time display scanner for a common-anode seven-segment board.
// Each digit owns a slot of SCAN_DIV clocks whose first BLANK_CYC clocks keep
// every anode off to avoid ghosting. The six BCD inputs are captured once per
// frame so a frame never mixes two time values. an/seg/dp are registered.
// Optional feature: define SEG_BLINK_EN to blink the field selected by
// select_time (half-period BLINK_DIV clocks) while change_out is high.
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int SCAN_DIV  = 100_000,
   parameter int BLANK_CYC = 1_000,
   parameter int BLINK_DIV = 50_000_000
)(
   input  logic       clk_100MHz,
   input  logic       rst_time,
   input  logic [3:0] L_sec,
   input  logic [3:0] H_sec,
   input  logic [3:0] L_min,
   input  logic [3:0] H_min,
   input  logic [3:0] L_hour,
   input  logic [3:0] H_hour,
   input  logic [1:0] select_time,
   input  logic       change_out,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int               CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
   localparam logic [2:0]       POS_LAST  = 3'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] cnt;
   logic [2:0]       pos;
   logic             slot_end;
   logic             frame_end;

   logic [3:0] snap_l_sec, snap_h_sec, snap_l_min, snap_h_min, snap_l_hour, snap_h_hour;
   logic [3:0] cur_digit;
   logic [6:0] cur_seg;

   logic       blank_sel;
   logic [7:0] an_next;
   logic       dp_next;

   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = slot_end && (pos == POS_LAST);

   // Slot counter and digit position: pos steps 0..5 at the end of each slot.
   always_ff @(posedge clk_100MHz or negedge rst_time) begin
      if (!rst_time) begin
         cnt <= '0;
         pos <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         pos <= (pos == POS_LAST) ? 3'd0 : pos + 3'd1;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Capture all six digits together as the frame wraps back to position 0.
   always_ff @(posedge clk_100MHz or negedge rst_time) begin
      if (!rst_time) begin
         snap_l_sec  <= '0;
         snap_h_sec  <= '0;
         snap_l_min  <= '0;
         snap_h_min  <= '0;
         snap_l_hour <= '0;
         snap_h_hour <= '0;
      end else if (frame_end) begin
         snap_l_sec  <= L_sec;
         snap_h_sec  <= H_sec;
         snap_l_min  <= L_min;
         snap_h_min  <= H_min;
         snap_l_hour <= L_hour;
         snap_h_hour <= H_hour;
      end
   end

   // Pick the captured digit belonging to the current position.
   always_comb begin
      cur_digit = 4'd0;
      case (pos)
         3'd0:    cur_digit = snap_l_sec;
         3'd1:    cur_digit = snap_h_sec;
         3'd2:    cur_digit = snap_l_min;
         3'd3:    cur_digit = snap_h_min;
         3'd4:    cur_digit = snap_l_hour;
         3'd5:    cur_digit = snap_h_hour;
         default: cur_digit = 4'd0;
      endcase
   end

   seg_bcd_decoder u_decoder (
      .bcd (cur_digit),
      .seg (cur_seg)
   );

`ifdef SEG_BLINK_EN
   localparam int               BLK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

   logic [BLK_W-1:0] blink_cnt;
   logic             blink_phase;
   sel_field_t       sel_q;

   // Blink timebase runs only in set mode; leaving set mode parks it in the lit phase.
   always_ff @(posedge clk_100MHz or negedge rst_time) begin
      if (!rst_time) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (!change_out) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + BLK_W'(1);
      end
   end

   // Selected field is taken at slot boundaries so a change never cuts a slot short.
   always_ff @(posedge clk_100MHz or negedge rst_time) begin
      if (!rst_time) begin
         sel_q <= SEL_NONE;
      end else if (slot_end) begin
         sel_q <= sel_field_t'(select_time);
      end
   end

   // Both digits of the selected field go dark during the off half of the blink.
   always_comb begin
      blank_sel = change_out && blink_phase && (sel_q != SEL_NONE) &&
                  ({1'b0, sel_q} == (pos >> 1));
   end
`else
   logic unused_blink_inputs;
   assign unused_blink_inputs = ^{change_out, select_time};
   assign blank_sel           = 1'b0;
`endif

   // Next anode and decimal-point values from the scan state.
   always_comb begin
      an_next = anode_for(pos);
      if ((cnt < CNT_BLANK) || blank_sel) begin
         an_next = ANODE_OFF;
      end
      dp_next = !((pos == 3'd2) || (pos == 3'd4));
   end

   // Register the pins one clock behind the scan state.
   always_ff @(posedge clk_100MHz or negedge rst_time) begin
      if (!rst_time) begin
         an  <= ANODE_OFF;
         seg <= SEG_OFF;
         dp  <= 1'b1;
      end else begin
         an  <= an_next;
         seg <= cur_seg;
         dp  <= dp_next;
      end
   end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display with small timing parameters. A cycle-level
// model derives the expected pins from elapsed cycles since reset, the
// captured frame digits and the length of the current set-mode run.
module tb_seg_scan_display;

   localparam int SCAN_DIV  = 10;
   localparam int BLANK_CYC = 2;
   localparam int BLINK_DIV = 40;

   logic       clk_100MHz  = 1'b0;
   logic       rst_time    = 1'b1;
   logic [3:0] L_sec       = 4'd0;
   logic [3:0] H_sec       = 4'd0;
   logic [3:0] L_min       = 4'd0;
   logic [3:0] H_min       = 4'd0;
   logic [3:0] L_hour      = 4'd0;
   logic [3:0] H_hour      = 4'd0;
   logic [1:0] select_time = 2'd3;
   logic       change_out  = 1'b0;
   logic [7:0] an;
   logic [6:0] seg;
   logic       dp;

   seg_scan_display #(
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC),
      .BLINK_DIV (BLINK_DIV)
   ) dut (
      .clk_100MHz  (clk_100MHz),
      .rst_time    (rst_time),
      .L_sec       (L_sec),
      .H_sec       (H_sec),
      .L_min       (L_min),
      .H_min       (H_min),
      .L_hour      (L_hour),
      .H_hour      (H_hour),
      .select_time (select_time),
      .change_out  (change_out),
      .an          (an),
      .seg         (seg),
      .dp          (dp)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   int n_checks = 0;
   int n_fail   = 0;
   bit run_checks = 1'b0;

   // Seven-segment patterns written out from the digit shapes.
   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0:       return 7'b1000000;
         1:       return 7'b1111001;
         2:       return 7'b0100100;
         3:       return 7'b0110000;
         4:       return 7'b0011001;
         5:       return 7'b0010010;
         6:       return 7'b0000010;
         7:       return 7'b1111000;
         8:       return 7'b0000000;
         9:       return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   // Model state: m_t = clock edges since reset release.
   int         m_t = 0;
   int         m_run = 0;
   int         m_sel = 3;
   int         m_snap [6];
   int         m_cnt, m_pos;
   bit         m_blank;
   logic [7:0] exp_an  = 8'hFF;
   logic [6:0] exp_seg = 7'h7F;
   logic       exp_dp  = 1'b1;

   // Reference model: outputs after an edge describe the state before it.
   always @(posedge clk_100MHz or negedge rst_time) begin
      if (!rst_time) begin
         m_t   = 0;
         m_run = 0;
         m_sel = 3;
         for (int i = 0; i < 6; i++) m_snap[i] = 0;
         exp_an  = 8'hFF;
         exp_seg = 7'h7F;
         exp_dp  = 1'b1;
      end else begin
         m_cnt   = m_t % SCAN_DIV;
         m_pos   = (m_t / SCAN_DIV) % 6;
         exp_seg = seg_of(m_snap[m_pos]);
         exp_dp  = !(m_pos == 2 || m_pos == 4);
         m_blank = (m_cnt < BLANK_CYC);
`ifdef SEG_BLINK_EN
         if (change_out && ((m_run / BLINK_DIV) % 2 == 1) && (m_sel == m_pos / 2)) m_blank = 1'b1;
         m_run = change_out ? m_run + 1 : 0;
`endif
         exp_an = m_blank ? 8'hFF : ~(8'h01 << m_pos);
         if (m_cnt == SCAN_DIV - 1) begin
            m_sel = int'(select_time);
            if (m_pos == 5) begin
               m_snap[0] = int'(L_sec);
               m_snap[1] = int'(H_sec);
               m_snap[2] = int'(L_min);
               m_snap[3] = int'(H_min);
               m_snap[4] = int'(L_hour);
               m_snap[5] = int'(H_hour);
            end
         end
         m_t = m_t + 1;
      end
   end

   // Hand-computed expectations requested by the stimulus process.
   string      pin_name;
   logic [7:0] pin_an;
   logic [6:0] pin_seg;
   logic       pin_dp;
   int         pin_req  = 0;
   int         pin_done = 0;

   // Single compare process: model check every cycle plus any pinned literal.
   always @(negedge clk_100MHz) begin
      if (run_checks) begin
         n_checks++;
         if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
            n_fail++;
            $display("[TB] FAIL model t=%0d: got an=%h seg=%b dp=%b, want an=%h seg=%b dp=%b",
                     m_t, an, seg, dp, exp_an, exp_seg, exp_dp);
         end
      end
      if (pin_req != pin_done) begin
         pin_done = pin_req;
         n_checks++;
         if (an !== pin_an || seg !== pin_seg || dp !== pin_dp) begin
            n_fail++;
            $display("[TB] FAIL %s: got an=%h seg=%b dp=%b, want an=%h seg=%b dp=%b",
                     pin_name, an, seg, dp, pin_an, pin_seg, pin_dp);
         end
      end
   end

   task automatic applyStimulus(input logic [3:0] hh, input logic [3:0] lh,
                                input logic [3:0] hm, input logic [3:0] lm,
                                input logic [3:0] hs, input logic [3:0] ls,
                                input logic co, input logic [1:0] sel);
      H_hour = hh; L_hour = lh; H_min = hm; L_min = lm; H_sec = hs; L_sec = ls;
      change_out = co; select_time = sel;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] a,
                              input logic [6:0] s, input logic d);
      pin_name = name; pin_an = a; pin_seg = s; pin_dp = d;
      pin_req++;
      @(negedge clk_100MHz);
      #1;
   endtask

   task automatic waitEdge(input int n);
      for (int k = 0; k < 100000 && m_t < n; k++) begin
         @(posedge clk_100MHz);
         #1;
      end
      #1;
   endtask

   task automatic pulseReset();
      @(posedge clk_100MHz); #2;
      rst_time = 1'b0;
      @(posedge clk_100MHz); #2;
      rst_time = 1'b1;
   endtask

   logic [7:0] frame_an  [6] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};
   logic [6:0] frame_seg [6] = '{7'b0000000, 7'b0010010, 7'b0010000,
                                 7'b0010010, 7'b0110000, 7'b0100100};
   logic       frame_dp  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      applyStimulus(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd8, 1'b0, 2'd3);
      #1 rst_time = 1'b0;
      run_checks = 1'b1;
      @(posedge clk_100MHz); @(posedge clk_100MHz); #2;
      rst_time = 1'b1;

      // Start-up: blank slot start, then pos0 showing the zeroed capture.
      waitEdge(1);
      checkOutput("post_reset_blank", 8'hFF, 7'b1000000, 1'b1);
      waitEdge(3);
      checkOutput("first_lit_pos0", 8'hFE, 7'b1000000, 1'b1);
      waitEdge(61);
      checkOutput("frame2_blank", 8'hFF, 7'b0000000, 1'b1);

      // 23:59:58 frame, with new inputs applied while pos3 is showing.
      for (int p = 0; p < 6; p++) begin
         waitEdge(66 + 10 * p);
         checkOutput($sformatf("frame_pos%0d", p), frame_an[p], frame_seg[p], frame_dp[p]);
         if (p == 3) applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'hC, 1'b0, 2'd3);
      end
      waitEdge(126);
      checkOutput("dash_pos0", 8'hFE, 7'b0111111, 1'b1);
      waitEdge(136);
      checkOutput("new_hsec", 8'hFD, 7'b1111000, 1'b1);
      waitEdge(156);
      checkOutput("new_hmin", 8'hF7, 7'b0110000, 1'b1);
      waitEdge(164);
      checkOutput("pre_reset_pos4", 8'hEF, 7'b0100100, 1'b0);

      // Asynchronous reset at pos4, cnt 5.
      @(posedge clk_100MHz); #2;
      rst_time = 1'b0;
      checkOutput("reset_async", 8'hFF, 7'h7F, 1'b1);
      @(posedge clk_100MHz); #2;
      rst_time = 1'b1;
      waitEdge(3);
      checkOutput("restart_pos0", 8'hFE, 7'b1000000, 1'b1);
      waitEdge(13);
      checkOutput("restart_pos1", 8'hFD, 7'b1000000, 1'b1);

      // Set mode on the minutes field from reset.
      applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 2'd1);
      pulseReset();
      waitEdge(26);
      checkOutput("blink_lit_pos2", 8'hFB, 7'b1000000, 1'b0);
      waitEdge(126);
      checkOutput("blink_other_pos0", 8'hFE, 7'b1000000, 1'b1);
`ifdef SEG_BLINK_EN
      waitEdge(146);
      checkOutput("blink_off_pos2", 8'hFF, 7'b1000000, 1'b0);
      waitEdge(156);
      checkOutput("blink_off_pos3", 8'hFF, 7'b1000000, 1'b1);
`else
      waitEdge(146);
      checkOutput("noblink_pos2", 8'hFB, 7'b1000000, 1'b0);
      waitEdge(156);
      checkOutput("noblink_pos3", 8'hF7, 7'b1000000, 1'b1);
`endif
      waitEdge(166);
      checkOutput("blink_pos4", 8'hEF, 7'b1000000, 1'b0);
      applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 2'd0);
      waitEdge(206);
      checkOutput("sel_moved_pos2", 8'hFB, 7'b1000000, 1'b0);
`ifdef SEG_BLINK_EN
      waitEdge(306);
      checkOutput("sel_sec_off_pos0", 8'hFF, 7'b1000000, 1'b1);
`else
      waitEdge(306);
      checkOutput("sel_sec_pos0", 8'hFE, 7'b1000000, 1'b1);
`endif
      applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0);
      waitEdge(346);
      checkOutput("setmode_off_pos4", 8'hEF, 7'b1000000, 1'b0);

      // Randomized traffic checked against the model every cycle.
      pulseReset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0)
            applyStimulus(4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
                          4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
                          4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
                          change_out, select_time);
         if ($urandom_range(0, 299) == 0) change_out = ~change_out;
         if ($urandom_range(0, 99) == 0) select_time = 2'($urandom_range(0, 3));
         if (i == 1500) pulseReset();
         @(posedge clk_100MHz); #2;
      end

      @(negedge clk_100MHz); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
